// File: rtl/dpll_sequencer.sv
// DPLL controller: launches the propagation kernel, decides, backtracks
// through a stack of saved formulas and reports SAT/UNSAT to the host.
package common;
  typedef struct packed {
    logic [2:0] id;
    logic       pol;
  } lit;

  typedef struct packed {
    lit [4:0]   lits;
    logic [2:0] len;
  } clause;

  typedef struct packed {
    clause [9:0] cls;
    logic [3:0]  count;
  } formula;

  localparam lit zero_lit = '0;
endpackage

module dpll_sequencer
  import common::*;
#(
  parameter int DEPTH   = 7,
  parameter int TIMEOUT = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  formula     in_formula,
  output logic       busy,
  output logic       done,
  output logic       result_sat,
  output logic       result_unsat,
  output logic       error,
  output logic [7:0] decisions,
  output logic [7:0] backtracks,
  output logic       kern_find,
  output formula     kern_formula,
  input  logic       kern_ended,
  input  formula     kern_out,
  input  logic       kern_sat,
  input  logic       kern_unsat,
  input  lit         kern_lit
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << AW;
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DECIDE,
    BACKTRACK,
    FINISH
  } state_t;

  state_t        state;
  logic [AW:0]   sp;
  logic [AW:0]   top;
  logic [TW-1:0] tmr;
  formula        kout;
  lit            klit;
  lit            flip;
  logic          full;

  formula stk_f [SLOTS];
  lit     stk_l [SLOTS];

  // Drop literal l from the formula: satisfied clauses vanish, ~l
  // is struck from the rest, survivors slide toward index 0.
  function automatic formula apply(input formula f, input lit l);
    formula     r;
    lit         nl;
    clause      c;
    logic       hit;
    logic [3:0] n;
    logic [2:0] k;
    nl     = l;
    nl.pol = ~l.pol;
    r      = '0;
    n      = '0;
    for (int i = 0; i < 10; i++) begin
      hit = 1'b0;
      c   = '0;
      k   = '0;
      for (int j = 0; j < 5; j++) begin
        if (3'(j) < f.cls[i].len) begin
          if (f.cls[i].lits[j] == l) begin
            hit = 1'b1;
          end else if (f.cls[i].lits[j] != nl) begin
            c.lits[k] = f.cls[i].lits[j];
            k = k + 3'd1;
          end
        end
      end
      c.len = k;
      if (4'(i) < f.count && !hit) begin
        r.cls[n] = c;
        n = n + 4'd1;
      end
    end
    r.count = n;
    return (l.id == 3'd0) ? f : r;
  endfunction

  assign top  = sp - 1'b1;
  assign full = (sp == FULL);

  always_comb begin
    flip     = klit;
    flip.pol = ~klit.pol;
  end

  always_ff @(posedge clock) begin
    if (state == DECIDE && !full) begin
      stk_f[sp[AW-1:0]] <= kout;
      stk_l[sp[AW-1:0]] <= flip;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_sat   <= 1'b0;
      result_unsat <= 1'b0;
      error        <= 1'b0;
      decisions    <= '0;
      backtracks   <= '0;
      kern_find    <= 1'b0;
      kern_formula <= '0;
      sp           <= '0;
      tmr          <= '0;
      kout         <= '0;
      klit         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            kern_formula <= in_formula;
            result_sat   <= 1'b0;
            result_unsat <= 1'b0;
            error        <= 1'b0;
            decisions    <= '0;
            backtracks   <= '0;
            sp           <= '0;
            busy         <= 1'b1;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          kern_find <= 1'b1;
          tmr       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (kern_ended) begin
            kern_find <= 1'b0;
            kout      <= kern_out;
            klit      <= kern_lit;
            if (kern_unsat) begin
              if (sp == '0) begin
                result_unsat <= 1'b1;
                state        <= FINISH;
              end else begin
                state <= BACKTRACK;
              end
            end else if (kern_sat) begin
              result_sat <= 1'b1;
              state      <= FINISH;
            end else begin
              state <= DECIDE;
            end
          end else if (tmr == TMAX) begin
            kern_find <= 1'b0;
            error     <= 1'b1;
            state     <= FINISH;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        DECIDE: begin
          if (full) begin
            error <= 1'b1;
            state <= FINISH;
          end else begin
            sp           <= sp + 1'b1;
            kern_formula <= apply(kout, klit);
            if (decisions != 8'hff) decisions <= decisions + 8'd1;
            state        <= LAUNCH;
          end
        end
        BACKTRACK: begin
          sp           <= top;
          kern_formula <= apply(stk_f[top[AW-1:0]], stk_l[top[AW-1:0]]);
          if (backtracks != 8'hff) backtracks <= backtracks + 8'd1;
          state        <= LAUNCH;
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpll_sequencer.sv
// Directed bench for dpll_sequencer: a scripted kernel, a queue of
// expected kernel formulas and a queue of expected verdicts.
module tb_dpll_sequencer;
  import common::*;

  typedef struct {
    logic       sat;
    logic       unsat;
    logic       err;
    logic [7:0] dec;
    logic [7:0] bt;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  formula     in_formula;
  logic       busy;
  logic       done;
  logic       result_sat;
  logic       result_unsat;
  logic       error;
  logic [7:0] decisions;
  logic [7:0] backtracks;
  logic       kern_find;
  formula     kern_formula;
  logic       kern_ended;
  formula     kern_out;
  logic       kern_sat;
  logic       kern_unsat;
  lit         kern_lit;

  int total  = 0;
  int passed = 0;

  exp_t   exp_q [$];
  formula fq    [$];

  dpll_sequencer #(.DEPTH(2), .TIMEOUT(1024)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .in_formula  (in_formula),
    .busy        (busy),
    .done        (done),
    .result_sat  (result_sat),
    .result_unsat(result_unsat),
    .error       (error),
    .decisions   (decisions),
    .backtracks  (backtracks),
    .kern_find   (kern_find),
    .kern_formula(kern_formula),
    .kern_ended  (kern_ended),
    .kern_out    (kern_out),
    .kern_sat    (kern_sat),
    .kern_unsat  (kern_unsat),
    .kern_lit    (kern_lit)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [233:0] obs,
                     input logic [233:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic lit mk_lit(input int id, input bit pol);
    lit r;
    r.id  = 3'(id);
    r.pol = pol;
    return r;
  endfunction

  function automatic clause mk_cl(input lit a, input lit b, input int n);
    clause c;
    c         = '0;
    c.lits[0] = a;
    c.lits[1] = b;
    c.len     = 3'(n);
    return c;
  endfunction

  function automatic formula mk_f(input clause a, input clause b,
                                  input int n);
    formula f;
    f        = '0;
    f.cls[0] = a;
    f.cls[1] = b;
    f.count  = 4'(n);
    return f;
  endfunction

  function automatic exp_t mk_exp(input bit s, input bit u, input bit e,
                                  input int d, input int b);
    exp_t x;
    x.sat   = s;
    x.unsat = u;
    x.err   = e;
    x.dec   = 8'(d);
    x.bt    = 8'(b);
    return x;
  endfunction

  task automatic do_start(input formula f, input exp_t e);
    @(negedge clock);
    in_formula = f;
    start      = 1'b1;
    fq.push_back(f);
    exp_q.push_back(e);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_find(input string tag);
    int n = 0;
    while (!kern_find && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk({tag, ".find"}, kern_find, 1);
    if (fq.size() != 0) chk({tag, ".formula"}, kern_formula, fq.pop_front());
  endtask

  task automatic respond(input bit s, input bit u, input formula o,
                         input lit l);
    kern_ended = 1'b1;
    kern_sat   = s;
    kern_unsat = u;
    kern_out   = o;
    kern_lit   = l;
    @(negedge clock);
    kern_ended = 1'b0;
    kern_sat   = 1'b0;
    kern_unsat = 1'b0;
    kern_out   = '0;
    kern_lit   = '0;
    chk("find_drop", kern_find, 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    exp_t e;
    int   n = 0;
    while (!done && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk({tag, ".done"}, done, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, ".sat"}, result_sat, e.sat);
      chk({tag, ".unsat"}, result_unsat, e.unsat);
      chk({tag, ".error"}, error, e.err);
      chk({tag, ".decisions"}, decisions, e.dec);
      chk({tag, ".backtracks"}, backtracks, e.bt);
    end
    chk({tag, ".busy"}, busy, 0);
    @(negedge clock);
    chk({tag, ".pulse"}, done, 0);
  endtask

  initial begin
    formula f1, f3, fx2, fo;
    lit     x1, nx1, x2;
    x1  = mk_lit(1, 1'b1);
    nx1 = mk_lit(1, 1'b0);
    x2  = mk_lit(2, 1'b1);
    f1  = mk_f(mk_cl(x1, zero_lit, 1), '0, 1);
    f3  = mk_f(mk_cl(x1, x2, 2), mk_cl(nx1, x2, 2), 2);
    fx2 = mk_f(mk_cl(x2, zero_lit, 1), '0, 1);
    fo  = mk_f(mk_cl(x2, x1, 2), '0, 1);

    reset      = 1'b1;
    start      = 1'b0;
    in_formula = '0;
    kern_ended = 1'b0;
    kern_out   = '0;
    kern_sat   = 1'b0;
    kern_unsat = 1'b0;
    kern_lit   = '0;
    repeat (2) @(negedge clock);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.find", kern_find, 0);
    chk("rst.kf", kern_formula, '0);
    chk("rst.flags", {result_sat, result_unsat, error}, 0);
    chk("rst.counts", {decisions, backtracks}, 0);
    reset = 1'b0;

    // single clause, kernel reports sat on the first run
    do_start(f1, mk_exp(1, 0, 0, 0, 0));
    chk("t1.busy", busy, 1);
    chk("t1.early", kern_find, 0);
    @(negedge clock);
    wait_find("t1");
    respond(1'b1, 1'b0, f1, zero_lit);
    chk("t1.lat", done, 0);
    wait_done("t1", 5);
    chk("t1.hold", result_sat, 1);

    // sat and unsat together count as unsat; start while busy ignored
    do_start(f1, mk_exp(0, 1, 0, 0, 0));
    wait_find("t2");
    in_formula = fo;
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("t2.ignore", kern_formula, f1);
    respond(1'b1, 1'b1, f1, zero_lit);
    wait_done("t2", 5);

    // decide x1, conflict, backtrack to ~x1, conflict again
    do_start(f3, mk_exp(0, 1, 0, 1, 1));
    wait_find("t3");
    fq.push_back(fx2);
    respond(1'b0, 1'b0, f3, x1);
    wait_find("t3.dec");
    chk("t3.decisions", decisions, 1);
    fq.push_back(fx2);
    respond(1'b0, 1'b1, '0, zero_lit);
    wait_find("t4.bt");
    chk("t4.backtracks", backtracks, 1);
    respond(1'b0, 1'b1, '0, zero_lit);
    wait_done("t4", 5);

    // stack of two fills up, third decision overflows
    do_start(fx2, mk_exp(0, 0, 1, 2, 0));
    wait_find("t5.r1");
    fq.push_back(fx2);
    respond(1'b0, 1'b0, fx2, x1);
    wait_find("t5.r2");
    fq.push_back(fx2);
    respond(1'b0, 1'b0, fx2, x1);
    wait_find("t5.r3");
    respond(1'b0, 1'b0, fx2, x1);
    wait_done("t5", 5);

    // kernel never answers
    do_start(fx2, mk_exp(0, 0, 1, 0, 0));
    wait_find("tmo");
    wait_done("tmo", 1100);

    // reset in the middle of a kernel run
    do_start(fx2, mk_exp(0, 0, 0, 0, 0));
    wait_find("t6");
    reset = 1'b1;
    #1;
    chk("t6.find", kern_find, 0);
    chk("t6.busy", busy, 0);
    chk("t6.done", done, 0);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    fq.delete();

    do_start(f1, mk_exp(1, 0, 0, 0, 0));
    wait_find("t7");
    respond(1'b1, 1'b0, f1, zero_lit);
    wait_done("t7", 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
